peripheral_bus_arbiter: RTL and testbench



---
 rtl/peripheral_bus_pkg.sv | 21 ++
 rtl/peripheral_bus_rr_arbiter.sv | 30 +++
 rtl/peripheral_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_peripheral_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter and its sub-blocks.
package peripheral_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } bus_state_e;

  localparam int unsigned DEVICE_INDEX_MSB    = 15;
  localparam int unsigned DEVICE_INDEX_LSB    = 12;
  localparam int unsigned LOCAL_ADDRESS_WIDTH = 12;
  localparam int unsigned DATA_WIDTH          = 32;

  localparam logic [DATA_WIDTH-1:0] ERROR_DATA = 32'h0;

  function automatic logic device_valid(logic [3:0] idx, int unsigned count);
    return {28'd0, idx} < count;
  endfunction

endpackage

// File: rtl/peripheral_bus_rr_arbiter.sv
// Two-way round-robin arbiter; last_q remembers the most recent winner so the
// other requester wins the next tie. Resets favouring requester 0.
module peripheral_bus_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
    last_d = (advance_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Shares the peripheral bus between the core data port (r0) and the debug port (r1),
// sequencing each grant as one IDLE -> ACCESS -> RESPOND bus access.
module peripheral_bus_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int unsigned DEVICE_COUNT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           r0_request,
  input  logic                           r0_we,
  input  logic [15:0]                    r0_address,
  input  logic [3:0]                     r0_byteSelect,
  input  logic [DATA_WIDTH-1:0]          r0_dataWrite,
  output logic                           r0_acknowledge,
  output logic                           r0_error,
  output logic [DATA_WIDTH-1:0]          r0_dataRead,
  input  logic                           r1_request,
  input  logic                           r1_we,
  input  logic [15:0]                    r1_address,
  input  logic [3:0]                     r1_byteSelect,
  input  logic [DATA_WIDTH-1:0]          r1_dataWrite,
  output logic                           r1_acknowledge,
  output logic                           r1_error,
  output logic [DATA_WIDTH-1:0]          r1_dataRead,
  output logic                           peripheralBus_we,
  output logic                           peripheralBus_oe,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] peripheralBus_address,
  output logic [3:0]                     peripheralBus_byteSelect,
  output logic [DATA_WIDTH-1:0]          peripheralBus_dataWrite,
  output logic [DEVICE_COUNT-1:0]        deviceEnable,
  input  logic [DATA_WIDTH-1:0]          peripheralBus_dataRead,
  input  logic                           peripheralBus_requestOutput,
  input  logic                           peripheralBus_busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  bus_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [15:0]           addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  gid_q, gid_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            gnt;
  logic                  grant;

  peripheral_bus_rr_arbiter u_rr_arbiter (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    ({r1_request, r0_request}),
    .advance_i(grant),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    gid_d      = gid_q;
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    grant      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (r0_request || r1_request) begin
          grant   = 1'b1;
          gid_d   = gnt[1];
          we_d    = gnt[1] ? r1_we         : r0_we;
          addr_d  = gnt[1] ? r1_address    : r0_address;
          be_d    = gnt[1] ? r1_byteSelect : r0_byteSelect;
          wdata_d = gnt[1] ? r1_dataWrite  : r0_dataWrite;
          cnt_d   = '0;
          if (device_valid(addr_d[DEVICE_INDEX_MSB:DEVICE_INDEX_LSB], DEVICE_COUNT)) begin
            state_d = StAccess;
          end else begin
            // Unmapped device: answer with an error without touching the bus.
            state_d    = StRespond;
            rsp_err_d  = 1'b1;
            rsp_data_d = ERROR_DATA;
          end
        end
      end
      StAccess: begin
        if (peripheralBus_busy) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
            state_d    = StRespond;
            rsp_err_d  = 1'b1;
            rsp_data_d = ERROR_DATA;
          end
        end else begin
          state_d = StRespond;
          if (we_q) begin
            rsp_err_d  = 1'b0;
            rsp_data_d = ERROR_DATA;
          end else begin
            // No device claimed the read: report an error and return zero.
            rsp_err_d  = !peripheralBus_requestOutput;
            rsp_data_d = peripheralBus_requestOutput ? peripheralBus_dataRead : ERROR_DATA;
          end
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      gid_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      gid_q      <= gid_d;
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    peripheralBus_we         = 1'b0;
    peripheralBus_oe         = 1'b0;
    peripheralBus_address    = '0;
    peripheralBus_byteSelect = '0;
    peripheralBus_dataWrite  = '0;
    deviceEnable             = '0;
    if (state_q == StAccess) begin
      peripheralBus_we         = we_q;
      peripheralBus_oe         = !we_q;
      peripheralBus_address    = addr_q[LOCAL_ADDRESS_WIDTH-1:0];
      peripheralBus_byteSelect = be_q;
      peripheralBus_dataWrite  = wdata_q;
      for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
        deviceEnable[i] = ({28'd0, addr_q[DEVICE_INDEX_MSB:DEVICE_INDEX_LSB]} == i);
      end
    end
  end

  assign r0_acknowledge = (state_q == StRespond) && !gid_q;
  assign r1_acknowledge = (state_q == StRespond) && gid_q;
  assign r0_error       = r0_acknowledge && rsp_err_q;
  assign r1_error       = r1_acknowledge && rsp_err_q;
  assign r0_dataRead    = r0_acknowledge ? rsp_data_q : '0;
  assign r1_dataRead    = r1_acknowledge ? rsp_data_q : '0;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Bench for peripheral_bus_arbiter: directed vector table, contention and reset
// sequences, then random traffic against a transaction-level model.
module tb_peripheral_bus_arbiter;

  localparam int unsigned DevCount = 8;
  localparam int unsigned Timeout  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_request = 1'b0, r0_we = 1'b0;
  logic [15:0] r0_address = '0;
  logic [3:0]  r0_byteSelect = '0;
  logic [31:0] r0_dataWrite = '0;
  logic        r0_acknowledge, r0_error;
  logic [31:0] r0_dataRead;
  logic        r1_request = 1'b0, r1_we = 1'b0;
  logic [15:0] r1_address = '0;
  logic [3:0]  r1_byteSelect = '0;
  logic [31:0] r1_dataWrite = '0;
  logic        r1_acknowledge, r1_error;
  logic [31:0] r1_dataRead;
  logic        peripheralBus_we, peripheralBus_oe;
  logic [11:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite;
  logic [7:0]  deviceEnable;
  logic [31:0] peripheralBus_dataRead = '0;
  logic        peripheralBus_requestOutput = 1'b0;
  logic        peripheralBus_busy = 1'b0;

  peripheral_bus_arbiter #(
    .DEVICE_COUNT  (DevCount),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .r0_request                 (r0_request),
    .r0_we                      (r0_we),
    .r0_address                 (r0_address),
    .r0_byteSelect              (r0_byteSelect),
    .r0_dataWrite               (r0_dataWrite),
    .r0_acknowledge             (r0_acknowledge),
    .r0_error                   (r0_error),
    .r0_dataRead                (r0_dataRead),
    .r1_request                 (r1_request),
    .r1_we                      (r1_we),
    .r1_address                 (r1_address),
    .r1_byteSelect              (r1_byteSelect),
    .r1_dataWrite               (r1_dataWrite),
    .r1_acknowledge             (r1_acknowledge),
    .r1_error                   (r1_error),
    .r1_dataRead                (r1_dataRead),
    .peripheralBus_we           (peripheralBus_we),
    .peripheralBus_oe           (peripheralBus_oe),
    .peripheralBus_address      (peripheralBus_address),
    .peripheralBus_byteSelect   (peripheralBus_byteSelect),
    .peripheralBus_dataWrite    (peripheralBus_dataWrite),
    .deviceEnable               (deviceEnable),
    .peripheralBus_dataRead     (peripheralBus_dataRead),
    .peripheralBus_requestOutput(peripheralBus_requestOutput),
    .peripheralBus_busy         (peripheralBus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          id;
    txn_t        t;
    logic [31:0] dev_rdata;
    logic        dev_ro;
    int          busy;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [63:0] exp_snap;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] snap(logic [7:0] en, logic we, logic oe, logic [11:0] a,
                                       logic [3:0] be, logic [31:0] wd);
    return {6'd0, en, we, oe, a, be, wd};
  endfunction

  function automatic logic [63:0] bus_now();
    return snap(deviceEnable, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                peripheralBus_byteSelect, peripheralBus_dataWrite);
  endfunction

  function automatic logic [63:0] exp_access(txn_t t);
    logic [7:0] one = 8'h01;
    return snap(one << t.addr[15:12], t.we, !t.we, t.addr[11:0], t.be, t.wdata);
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 16'($urandom);
    t.addr[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                : 4'($urandom_range(0, 7));
    t.be    = 4'($urandom);
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic drive_req(input int id, input logic on, input txn_t t);
    if (id == 0) begin
      r0_request = on; r0_we = t.we; r0_address = t.addr;
      r0_byteSelect = t.be; r0_dataWrite = t.wdata;
    end else begin
      r1_request = on; r1_we = t.we; r1_address = t.addr;
      r1_byteSelect = t.be; r1_dataWrite = t.wdata;
    end
  endtask

  // Entered at #1 into an IDLE cycle with requests driven; returns at #1 into the
  // IDLE cycle that follows the acknowledge.
  task automatic run_txn(input int id, input int busy_n, input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_data, input logic [63:0] exp_snap,
                         input string tag);
    int          lat = 0, strobes = 0, noise = 0;
    logic        err = 1'b0, ao, eo, ax, ex;
    logic [31:0] data = '0, dto, dtx;
    logic [63:0] first = '0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      peripheralBus_busy = (k <= busy_n);
      if (k == 1) first = bus_now();
      if (deviceEnable != 0 || peripheralBus_we || peripheralBus_oe) strobes++;
      if (id == 0) begin
        ao = r0_acknowledge; eo = r0_error; dto = r0_dataRead;
        ax = r1_acknowledge; ex = r1_error; dtx = r1_dataRead;
      end else begin
        ao = r1_acknowledge; eo = r1_error; dto = r1_dataRead;
        ax = r0_acknowledge; ex = r0_error; dtx = r0_dataRead;
      end
      if (ax || ex || dtx != 0) noise++;
      if (ao) begin
        lat = k; err = eo; data = dto;
      end else if (eo || dto != 0) begin
        noise++;
      end
    end
    peripheralBus_busy = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/error"}, 64'(err), 64'(exp_err));
    check({tag, "/data"}, 64'(data), 64'(exp_data));
    check({tag, "/bus"}, first, exp_snap);
    check({tag, "/strobe_cycles"}, 64'(strobes), 64'(exp_lat - 1));
    check({tag, "/stray_outputs"}, 64'(noise), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t        ta, tb;
    bit          pend[2];
    txn_t        ptx[2];
    int          last, win, b, lat;
    logic        err;
    logic [31:0] data;
    logic [63:0] sn;
    logic        ack_seen;

    vecs[0] = '{0, '{1'b1, 16'h2004, 4'hF, 32'hA5A5_0F0F}, 32'h0, 1'b0, 0, 2, 1'b0, 32'h0,
                snap(8'h04, 1'b1, 1'b0, 12'h004, 4'hF, 32'hA5A5_0F0F)};
    vecs[1] = '{1, '{1'b0, 16'h1000, 4'hF, 32'h0}, 32'h1234_5678, 1'b1, 0, 2, 1'b0,
                32'h1234_5678, snap(8'h02, 1'b0, 1'b1, 12'h000, 4'hF, 32'h0)};
    vecs[2] = '{0, '{1'b0, 16'h3010, 4'h3, 32'h0}, 32'hDEAD_BEEF, 1'b0, 0, 2, 1'b1, 32'h0,
                snap(8'h08, 1'b0, 1'b1, 12'h010, 4'h3, 32'h0)};
    vecs[3] = '{1, '{1'b1, 16'hA000, 4'hF, 32'h55AA_55AA}, 32'h0, 1'b1, 0, 1, 1'b1, 32'h0,
                64'h0};
    vecs[4] = '{0, '{1'b0, 16'h5ABC, 4'hC, 32'h0}, 32'hCAFE_F00D, 1'b1, 3, 5, 1'b0,
                32'hCAFE_F00D, snap(8'h20, 1'b0, 1'b1, 12'hABC, 4'hC, 32'h0)};
    vecs[5] = '{1, '{1'b1, 16'h7FFF, 4'h1, 32'h0102_0304}, 32'h0, 1'b1, 40, 17, 1'b1, 32'h0,
                snap(8'h80, 1'b1, 1'b0, 12'hFFF, 4'h1, 32'h0102_0304)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset/bus", bus_now(), 64'h0);
    check("reset/resp", 64'({r0_acknowledge, r0_error, r1_acknowledge, r1_error,
                             r0_dataRead | r1_dataRead}), 64'h0);
    rst = 1'b0;

    // Directed vectors, one requester at a time
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].id, 1'b1, vecs[i].t);
      peripheralBus_dataRead      = vecs[i].dev_rdata;
      peripheralBus_requestOutput = vecs[i].dev_ro;
      run_txn(vecs[i].id, vecs[i].busy, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_data,
              vecs[i].exp_snap, $sformatf("vec%0d", i));
      drive_req(vecs[i].id, 1'b0, vecs[i].t);
    end

    // Contention: both held for four transactions, r0 wins first after reset
    ta = '{1'b0, 16'h1004, 4'hF, 32'h0};
    tb = '{1'b0, 16'h6008, 4'h5, 32'h0};
    peripheralBus_dataRead      = 32'h1111_2222;
    peripheralBus_requestOutput = 1'b1;
    rst_pulse();
    drive_req(0, 1'b1, ta);
    drive_req(1, 1'b1, tb);
    for (int i = 0; i < 4; i++) begin
      run_txn(i % 2, 0, 2, 1'b0, 32'h1111_2222, exp_access((i % 2 == 0) ? ta : tb),
              $sformatf("contend%0d", i));
    end
    drive_req(0, 1'b0, ta);
    drive_req(1, 1'b0, tb);

    // Asynchronous reset while stalled in ACCESS
    rst_pulse();
    drive_req(0, 1'b1, ta);
    peripheralBus_busy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("midreset/in_access", 64'(deviceEnable), 64'h02);
    #2;
    rst = 1'b1;
    #1;
    check("midreset/bus_cleared", bus_now(), 64'h0);
    check("midreset/resp_cleared", 64'({r0_acknowledge, r0_error, r1_acknowledge, r1_error}),
          64'h0);
    drive_req(1, 1'b1, tb);
    ack_seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      ack_seen |= r0_acknowledge | r1_acknowledge;
    end
    check("midreset/no_ack", 64'(ack_seen), 64'h0);
    rst = 1'b0;
    peripheralBus_busy = 1'b0;
    run_txn(0, 0, 2, 1'b0, 32'h1111_2222, exp_access(ta), "midreset/r0_first");
    drive_req(0, 1'b0, ta);
    run_txn(1, 0, 2, 1'b0, 32'h1111_2222, exp_access(tb), "midreset/r1_next");
    drive_req(1, 1'b0, tb);

    // Random traffic against a transaction-level model
    rst_pulse();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last    = 1;
    for (int s = 0; s < 60; s++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          ptx[r]  = rand_txn();
          pend[r] = 1'b1;
          drive_req(r, 1'b1, ptx[r]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        @(posedge clk); #1;
        check($sformatf("rand%0d/idle_quiet", s), bus_now(), 64'h0);
        continue;
      end
      // Ties go to whoever did not win last; any grant becomes the new last winner.
      if (pend[0] && pend[1]) win = (last == 1) ? 0 : 1;
      else                    win = pend[0] ? 0 : 1;
      last = win;
      peripheralBus_dataRead      = $urandom;
      peripheralBus_requestOutput = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
      if (int'(ptx[win].addr[15:12]) >= int'(DevCount)) begin
        lat = 1; err = 1'b1; data = 32'h0; sn = 64'h0;
      end else begin
        sn = exp_access(ptx[win]);
        if (b >= int'(Timeout)) begin
          lat = int'(Timeout) + 1; err = 1'b1; data = 32'h0;
        end else begin
          lat  = 2 + b;
          err  = ptx[win].we ? 1'b0 : !peripheralBus_requestOutput;
          data = (ptx[win].we || err) ? 32'h0 : peripheralBus_dataRead;
        end
      end
      run_txn(win, b, lat, err, data, sn, $sformatf("rand%0d/r%0d", s, win));
      pend[win] = 1'b0;
      drive_req(win, 1'b0, ptx[win]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
